// File: rtl/axil_fram_regs.sv
// rtl/axil_fram_regs.sv - AXI4-Lite register front end issuing single FRAM read/write commands
module axil_fram_regs #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 4,
  parameter int MEM_ADDR_WIDTH = 11
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [ADDR_WIDTH-1:0]     s_axil_awaddr,
  input  logic                      s_axil_awvalid,
  output logic                      s_axil_awready,
  input  logic [DATA_WIDTH-1:0]     s_axil_wdata,
  input  logic [DATA_WIDTH/8-1:0]   s_axil_wstrb,
  input  logic                      s_axil_wvalid,
  output logic                      s_axil_wready,
  output logic [1:0]                s_axil_bresp,
  output logic                      s_axil_bvalid,
  input  logic                      s_axil_bready,
  input  logic [ADDR_WIDTH-1:0]     s_axil_araddr,
  input  logic                      s_axil_arvalid,
  output logic                      s_axil_arready,
  output logic [DATA_WIDTH-1:0]     s_axil_rdata,
  output logic [1:0]                s_axil_rresp,
  output logic                      s_axil_rvalid,
  input  logic                      s_axil_rready,
  output logic                      cmd_valid,
  input  logic                      cmd_ready,
  output logic                      cmd_write,
  output logic [MEM_ADDR_WIDTH-1:0] cmd_addr,
  output logic [DATA_WIDTH-1:0]     cmd_wdata,
  input  logic                      rsp_valid,
  input  logic [DATA_WIDTH-1:0]     rsp_rdata
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  state_t state, state_next;

  logic                      aw_held, w_held;
  logic [1:0]                aw_word;
  logic [DATA_WIDTH-1:0]     w_data;
  logic [STRB_WIDTH-1:0]     w_strb;
  logic [MEM_ADDR_WIDTH-1:0] addr_reg;
  logic [DATA_WIDTH-1:0]     wdata_reg, rdata_reg, addr_merged;
  logic                      busy, done;
  logic                      commit, cmd_hit, start, reject, ar_fire;
  logic                      unused_bits;

  function automatic logic [DATA_WIDTH-1:0] merge(input logic [DATA_WIDTH-1:0] old,
                                                  input logic [DATA_WIDTH-1:0] nw,
                                                  input logic [STRB_WIDTH-1:0] strb);
    logic [DATA_WIDTH-1:0] r;
    r = old;
    for (int i = 0; i < STRB_WIDTH; i++)
      if (strb[i]) r[8*i +: 8] = nw[8*i +: 8];
    return r;
  endfunction

  // Readies are gated by reset so nothing is offered to the bus while it is held
  assign s_axil_awready = rst && !aw_held && !s_axil_bvalid;
  assign s_axil_wready  = rst && !w_held && !s_axil_bvalid;
  assign s_axil_arready = rst && !s_axil_rvalid;
  assign s_axil_rresp   = 2'b00;

  assign busy        = (state != IDLE);
  assign cmd_valid   = (state == ISSUE);
  assign commit      = aw_held && w_held;
  assign cmd_hit     = commit && (aw_word == 2'd0) && w_strb[0] && (w_data[1:0] != 2'b00);
  assign start       = cmd_hit && !busy;
  assign reject      = cmd_hit && busy;
  assign ar_fire     = s_axil_arvalid && s_axil_arready;
  assign addr_merged = merge(DATA_WIDTH'(addr_reg), w_data, w_strb);
  assign unused_bits = ^{s_axil_awaddr[1:0], s_axil_araddr[1:0],
                         addr_merged[DATA_WIDTH-1:MEM_ADDR_WIDTH]};

  always_ff @(posedge clk) begin
    if (!rst) begin
      aw_held       <= 1'b0;
      w_held        <= 1'b0;
      aw_word       <= 2'd0;
      w_data        <= '0;
      w_strb        <= '0;
      s_axil_bvalid <= 1'b0;
      s_axil_bresp  <= 2'b00;
      addr_reg      <= '0;
      wdata_reg     <= '0;
    end else begin
      if (s_axil_awvalid && s_axil_awready) begin
        aw_held <= 1'b1;
        aw_word <= s_axil_awaddr[3:2];
      end
      if (s_axil_wvalid && s_axil_wready) begin
        w_held <= 1'b1;
        w_data <= s_axil_wdata;
        w_strb <= s_axil_wstrb;
      end
      if (commit) begin
        aw_held       <= 1'b0;
        w_held        <= 1'b0;
        s_axil_bvalid <= 1'b1;
        s_axil_bresp  <= reject ? 2'b10 : 2'b00;
        case (aw_word)
          2'd1:    addr_reg  <= addr_merged[MEM_ADDR_WIDTH-1:0];
          2'd2:    wdata_reg <= merge(wdata_reg, w_data, w_strb);
          default: ;
        endcase
      end else if (s_axil_bvalid && s_axil_bready) begin
        s_axil_bvalid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = ISSUE;
      ISSUE:   if (cmd_ready) state_next = WAIT;
      WAIT:    if (rsp_valid) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Command fields are snapshotted at start so later ADDR/DATA writes cannot disturb them
  always_ff @(posedge clk) begin
    if (!rst) begin
      cmd_write <= 1'b0;
      cmd_addr  <= '0;
      cmd_wdata <= '0;
      rdata_reg <= '0;
      done      <= 1'b0;
    end else begin
      if (start) begin
        cmd_write <= w_data[0];
        cmd_addr  <= addr_reg;
        cmd_wdata <= wdata_reg;
      end
      if (state == WAIT && rsp_valid) begin
        done <= 1'b1;
        if (!cmd_write) rdata_reg <= rsp_rdata;
      end else if (ar_fire && s_axil_araddr[3:2] == 2'd3) begin
        done <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      s_axil_rvalid <= 1'b0;
      s_axil_rdata  <= '0;
    end else if (ar_fire) begin
      s_axil_rvalid <= 1'b1;
      case (s_axil_araddr[3:2])
        2'd1:    s_axil_rdata <= DATA_WIDTH'(addr_reg);
        2'd2:    s_axil_rdata <= rdata_reg;
        2'd3:    s_axil_rdata <= {{(DATA_WIDTH-2){1'b0}}, done, busy};
        default: s_axil_rdata <= '0;
      endcase
    end else if (s_axil_rvalid && s_axil_rready) begin
      s_axil_rvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axil_fram_regs.sv
// tb/tb_axil_fram_regs.sv - randomized bench for axil_fram_regs against a register-level model
module tb_axil_fram_regs;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  s_axil_awaddr, s_axil_araddr;
  logic        s_axil_awvalid, s_axil_awready, s_axil_wvalid, s_axil_wready;
  logic [31:0] s_axil_wdata, s_axil_rdata;
  logic [3:0]  s_axil_wstrb;
  logic [1:0]  s_axil_bresp, s_axil_rresp;
  logic        s_axil_bvalid, s_axil_bready, s_axil_arvalid, s_axil_arready;
  logic        s_axil_rvalid, s_axil_rready;
  logic        cmd_valid, cmd_ready, cmd_write, rsp_valid;
  logic [10:0] cmd_addr;
  logic [31:0] cmd_wdata, rsp_rdata;

  always #5 clk = ~clk;

  axil_fram_regs dut (
    .clk(clk), .rst(rst),
    .s_axil_awaddr(s_axil_awaddr), .s_axil_awvalid(s_axil_awvalid), .s_axil_awready(s_axil_awready),
    .s_axil_wdata(s_axil_wdata), .s_axil_wstrb(s_axil_wstrb),
    .s_axil_wvalid(s_axil_wvalid), .s_axil_wready(s_axil_wready),
    .s_axil_bresp(s_axil_bresp), .s_axil_bvalid(s_axil_bvalid), .s_axil_bready(s_axil_bready),
    .s_axil_araddr(s_axil_araddr), .s_axil_arvalid(s_axil_arvalid), .s_axil_arready(s_axil_arready),
    .s_axil_rdata(s_axil_rdata), .s_axil_rresp(s_axil_rresp),
    .s_axil_rvalid(s_axil_rvalid), .s_axil_rready(s_axil_rready),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Register-level model: what software should observe through the map
  logic [10:0] m_addr;
  logic [31:0] m_wdata, m_rdata;
  bit          m_busy, m_done;
  bit          e_write;
  logic [10:0] e_addr;
  logic [31:0] e_wdata;

  task automatic model_reset();
    m_addr = '0; m_wdata = '0; m_rdata = '0; m_busy = 0; m_done = 0;
  endtask

  function automatic logic [31:0] bytes_merge(input logic [31:0] old, input logic [31:0] nw,
                                              input logic [3:0] s);
    logic [31:0] r, mask;
    r = old;
    for (int b = 0; b < 4; b++) begin
      mask = 32'hFF << (8 * b);
      if (s[b]) r = (r & ~mask) | (nw & mask);
    end
    return r;
  endfunction

  task automatic model_write(input logic [1:0] w, input logic [31:0] d, input logic [3:0] s,
                             output logic [1:0] resp);
    logic [31:0] t;
    resp = 2'b00;
    case (w)
      2'd0: if (s[0] && (d % 4) != 0) begin
        if (m_busy) resp = 2'b10;
        else begin
          m_busy = 1; e_write = d[0]; e_addr = m_addr; e_wdata = m_wdata;
        end
      end
      2'd1: begin t = bytes_merge({21'd0, m_addr}, d, s) % 2048; m_addr = t[10:0]; end
      2'd2: m_wdata = bytes_merge(m_wdata, d, s);
      default: ;
    endcase
  endtask

  task automatic model_read(input logic [1:0] w, output logic [31:0] v);
    case (w)
      2'd0: v = 32'd0;
      2'd1: v = {21'd0, m_addr};
      2'd2: v = m_rdata;
      default: begin v = (m_done ? 32'd2 : 32'd0) + (m_busy ? 32'd1 : 32'd0); m_done = 0; end
    endcase
  endtask

  task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp);
    int  n;
    logic aw_hs, w_hs;
    @(negedge clk);
    s_axil_awaddr = a; s_axil_awvalid = 1; s_axil_wdata = d; s_axil_wstrb = s; s_axil_wvalid = 1;
    n = 0;
    while ((s_axil_awvalid || s_axil_wvalid) && n < 50) begin
      aw_hs = s_axil_awvalid && s_axil_awready;
      w_hs  = s_axil_wvalid && s_axil_wready;
      @(negedge clk);
      if (aw_hs) s_axil_awvalid = 0;
      if (w_hs)  s_axil_wvalid = 0;
      n++;
    end
    s_axil_awvalid = 0; s_axil_wvalid = 0;
    s_axil_bready = 1;
    n = 0;
    while (!s_axil_bvalid && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) check("b_timeout", 0, 1);
    resp = s_axil_bresp;
    @(negedge clk);
    s_axil_bready = 0;
  endtask

  task automatic axi_read(input logic [3:0] a, output logic [31:0] d);
    int n;
    @(negedge clk);
    s_axil_araddr = a; s_axil_arvalid = 1; s_axil_rready = 1;
    n = 0;
    while (!s_axil_arready && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    s_axil_arvalid = 0;
    n = 0;
    while (!s_axil_rvalid && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) check("r_timeout", 0, 1);
    d = s_axil_rdata;
    @(negedge clk);
    s_axil_rready = 0;
  endtask

  task automatic reg_write(input logic [1:0] w, input logic [31:0] d, input logic [3:0] s);
    logic [1:0] exp_resp, got_resp;
    model_write(w, d, s, exp_resp);
    axi_write({w, 2'($urandom)}, d, s, got_resp);
    check($sformatf("bresp_w%0d", w), 32'(got_resp), 32'(exp_resp));
  endtask

  task automatic reg_read(input logic [1:0] w, output logic [31:0] v);
    logic [31:0] exp_v;
    axi_read({w, 2'($urandom)}, v);
    model_read(w, exp_v);
    check($sformatf("rdata_w%0d", w), v, exp_v);
  endtask

  task automatic pulse_rsp(input logic [31:0] rd);
    @(negedge clk);
    rsp_valid = 1; rsp_rdata = rd;
    @(negedge clk);
    rsp_valid = 0;
  endtask

  task automatic serve(input int ready_delay, input int rsp_delay, input logic [31:0] rd);
    repeat (ready_delay) begin
      @(negedge clk);
      check("cmd_valid_hold", 32'(cmd_valid), 1);
    end
    @(negedge clk);
    check("cmd_valid", 32'(cmd_valid), 1);
    check("cmd_write", 32'(cmd_write), 32'(e_write));
    check("cmd_addr", 32'(cmd_addr), 32'(e_addr));
    check("cmd_wdata", cmd_wdata, e_wdata);
    cmd_ready = 1;
    @(negedge clk);
    cmd_ready = 0;
    check("cmd_valid_drop", 32'(cmd_valid), 0);
    repeat (rsp_delay) @(negedge clk);
    pulse_rsp(rd);
    m_busy = 0; m_done = 1;
    if (!e_write) m_rdata = rd;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] v;
    int          op;

    rst = 0;
    s_axil_awaddr = 0; s_axil_araddr = 0; s_axil_wdata = 0; s_axil_wstrb = 0;
    s_axil_awvalid = 1; s_axil_wvalid = 1; s_axil_arvalid = 1;
    s_axil_bready = 1; s_axil_rready = 1;
    cmd_ready = 0; rsp_valid = 0; rsp_rdata = 0;
    model_reset();
    repeat (3) begin
      @(negedge clk);
      check("reset_hs", {26'd0, s_axil_awready, s_axil_wready, s_axil_arready,
                         s_axil_bvalid, s_axil_rvalid, cmd_valid}, 0);
    end
    s_axil_awvalid = 0; s_axil_wvalid = 0; s_axil_arvalid = 0;
    s_axil_bready = 0; s_axil_rready = 0;
    rst = 1;
    reg_read(2'd3, v);
    check("reset_status", v, 32'h0);

    // Write command sequence with a stalled backend
    reg_write(2'd1, 32'h005, 4'hF);
    reg_write(2'd2, 32'hA5A5A5A5, 4'hF);
    reg_write(2'd0, 32'h1, 4'hF);
    check("wr_cmd_write", 32'(cmd_write), 1);
    check("wr_cmd_addr", 32'(cmd_addr), 32'h005);
    check("wr_cmd_wdata", cmd_wdata, 32'hA5A5A5A5);
    reg_read(2'd3, v);
    check("wr_status_busy", v, 32'h1);
    serve(3, 1, $urandom);
    reg_read(2'd3, v);

    // Read command sequence
    reg_write(2'd0, 32'h2, 4'h1);
    serve(0, 2, 32'hA5A5A5A5);
    reg_read(2'd3, v);
    check("rd_status_done", v, 32'h2);
    reg_read(2'd3, v);
    check("rd_status_clr", v, 32'h0);
    reg_read(2'd2, v);
    check("rd_data", v, 32'hA5A5A5A5);

    // W leads AW by four cycles; B held off by bready
    @(negedge clk);
    s_axil_wdata = 32'h1234_5678; s_axil_wstrb = 4'hF; s_axil_wvalid = 1;
    @(negedge clk);
    s_axil_wvalid = 0;
    repeat (3) begin
      @(negedge clk);
      check("w_held_wready", 32'(s_axil_wready), 0);
    end
    s_axil_awaddr = 4'h8; s_axil_awvalid = 1;
    check("aw_open", 32'(s_axil_awready), 1);
    @(negedge clk);
    s_axil_awvalid = 0;
    check("b_lat1", 32'(s_axil_bvalid), 0);
    @(negedge clk);
    check("b_lat2", 32'(s_axil_bvalid), 1);
    begin
      logic [1:0] r;
      model_write(2'd2, 32'h1234_5678, 4'hF, r);
    end
    repeat (5) begin
      @(negedge clk);
      check("b_stall", {28'd0, s_axil_bvalid, s_axil_bresp, s_axil_awready | s_axil_wready},
            32'h8);
    end
    s_axil_bready = 1;
    @(negedge clk);
    s_axil_bready = 0;
    check("b_release", 32'(s_axil_bvalid), 0);

    // Busy collision and partial ADDR write
    reg_write(2'd1, 32'h0, 4'hF);
    reg_write(2'd0, 32'h1, 4'h1);
    reg_write(2'd0, 32'h1, 4'h1);
    reg_write(2'd1, 32'hFFFF_FFFF, 4'b0001);
    reg_read(2'd1, v);
    check("partial_addr", v, 32'h0FF);
    serve(1, 0, $urandom);
    repeat (4) begin
      @(negedge clk);
      check("no_second_cmd", 32'(cmd_valid), 0);
    end

    // Randomized mix
    for (int it = 0; it < 80; it++) begin
      op = $urandom_range(0, 9);
      if (op < 3)       reg_write(2'($urandom_range(1, 3)), $urandom, 4'($urandom));
      else if (op < 5)  reg_write(2'd0, $urandom, 4'($urandom));
      else if (op < 8)  reg_read(2'($urandom_range(0, 3)), v);
      else if (op == 8) pulse_rsp($urandom);
      else if (m_busy)  serve($urandom_range(0, 3), $urandom_range(0, 3), $urandom);
    end
    if (m_busy) serve(0, 0, $urandom);

    // Reset while waiting on the backend
    reg_write(2'd0, 32'h2, 4'hF);
    @(negedge clk);
    cmd_ready = 1;
    @(negedge clk);
    cmd_ready = 0;
    rst = 0;
    @(negedge clk);
    rst = 1;
    model_reset();
    check("rst_wait_cmd_valid", 32'(cmd_valid), 0);
    reg_read(2'd3, v);
    check("rst_wait_status", v, 32'h0);
    pulse_rsp(32'hDEAD_BEEF);
    reg_read(2'd3, v);
    check("late_rsp_status", v, 32'h0);
    reg_read(2'd2, v);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
